// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
// Shared definitions for the QSPI flash read sequencer: flash command
// bytes, FSM state encoding and SCK phase lengths.
// Read-mode option (used by the files importing this package):
// SPI_FLASH_QUAD_EN.
package spi_flash_pkg;

   localparam logic [7:0] CMD_READ         = 8'h03;
   localparam logic [7:0] CMD_QUAD_AD_READ = 8'hEB;

   // SCK pulses per phase (the flash always sees a 24-bit address)
   localparam int unsigned FLASH_ADDR_BITS = 24;
   localparam int unsigned CMD_SCK         = 8;
   localparam int unsigned ADDR_SCK_QUAD   = 6;
   localparam int unsigned ADDR_SCK_SINGLE = 24;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      RESP,
      GAP
   } state_t;

   // Terminal value of the SCK down-counter for the data phase:
   // quad moves 2 SCK per byte (2*len+1), single moves 8 SCK per byte (8*len+7).
   function automatic logic [7:0] data_sck_last(input logic quad, input logic [1:0] len);
      if (quad) data_sck_last = {5'b0, len, 1'b1};
      else      data_sck_last = {3'b0, len, 3'b111};
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// spi_sck_gen
// SCK generator for the flash read sequencer. While en is high, sck toggles
// every CLK_DIV clocks, the first toggle being a rise CLK_DIV clocks after en
// goes high. rise/fall are single-cycle strobes marking the clock edge on
// which sck will go high/low. While en is low, sck is held low and the
// divider is reloaded.
// Ports:
//   clock, reset (active-low async)
//   en          enable (high while cs is low)
//   sck         flash clock level
//   rise, fall  edge strobes for the sequencer
module spi_sck_gen #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tc;

   assign tc   = en && (div_cnt == '0);
   assign rise = tc && !sck;
   assign fall = tc &&  sck;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_cnt <= DIV_LAST;
         sck     <= 1'b0;
      end else if (!en) begin
         div_cnt <= DIV_LAST;
         sck     <= 1'b0;
      end else if (tc) begin
         div_cnt <= DIV_LAST;
         sck     <= ~sck;
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// spi_flash_read_ctrl
// Host-side read sequencer for the QSPI boot/ROM flash. Each fabric request
// runs a full flash read (command, address, optional dummy, data) and
// returns 1..4 bytes packed little-endian in resp_data.
// Build option: define SPI_FLASH_QUAD_EN for quad I/O read (0xEB, 4-bit
// address/data, dummy phase); otherwise plain read (0x03, address on dq[0],
// data on dq[1], no dummy phase).
// Ports:
//   clock, reset (active-low async)
//   req_valid/req_ready/req_addr/req_len   fabric request (len = bytes-1)
//   resp_valid/resp_ready/resp_data        response, held until accepted
//   sck, cs, dq_out, dq_drive, dq_in       flash pads
//   busy                                   sequencer not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request, cs high
// CMD   | shifting the command byte on dq[0]
// ADDR  | shifting the 24-bit address (nibbles in quad, bits in single)
// DUMMY | quad only: turnaround SCKs, pads released
// DATA  | capturing (len+1) bytes from the flash
// RESP  | cs high, response presented until resp handshake
// GAP   | enforcing minimum cs-high time before the next request
module spi_flash_read_ctrl
   import spi_flash_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = 24,
   parameter int unsigned DUMMY_CYCLES = 8,
   parameter int unsigned CLK_DIV      = 1,
   parameter int unsigned CS_GAP       = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [1:0]           req_len,
   output logic                 resp_valid,
   output logic [31:0]          resp_data,
   input  logic                 resp_ready,
   output logic                 sck,
   output logic                 cs,
   output logic [3:0]           dq_out,
   output logic [3:0]           dq_drive,
   input  logic [3:0]           dq_in,
   output logic                 busy
);

`ifdef SPI_FLASH_QUAD_EN
   localparam logic QUAD = 1'b1;
`else
   localparam logic QUAD = 1'b0;
`endif

   localparam logic [7:0] CMD_BYTE  = QUAD ? CMD_QUAD_AD_READ : CMD_READ;
   localparam logic [7:0] CMD_LAST  = 8'(CMD_SCK - 1);
   localparam logic [7:0] ADDR_LAST = QUAD ? 8'(ADDR_SCK_QUAD - 1) : 8'(ADDR_SCK_SINGLE - 1);
   // DUMMY_CYCLES is limited to 256 by the 8-bit phase counter
   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
   localparam logic       USE_DUMMY  = QUAD && (DUMMY_CYCLES != 0);

   localparam int unsigned      GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   state_t            state, state_nxt;
   logic              sck_en, sck_rise, sck_fall;
   logic              req_fire, resp_fire, phase_end;
   logic [7:0]        bit_cnt, phase_last;
   logic [31:0]       tx_sr;
   logic [1:0]        len_q;
   logic [31:0]       data_q;
   logic [7:0]        rx_byte, rx_byte_nxt;
   logic [4:0]        rx_cnt;
   logic [1:0]        byte_idx;
   logic              byte_done;
   logic [GAP_W-1:0]  gap_cnt;
   logic              resp_valid_q;
   logic              out_of_reset;
   logic [FLASH_ADDR_BITS-1:0] addr24;

   // Flash address is always 24 bits: zero-extend or truncate the fabric address.
   generate
      if (ADDR_BITS >= FLASH_ADDR_BITS) begin : g_addr_trunc
         assign addr24 = req_addr[FLASH_ADDR_BITS-1:0];
      end else begin : g_addr_ext
         assign addr24 = {{(FLASH_ADDR_BITS-ADDR_BITS){1'b0}}, req_addr};
      end
   endgenerate

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clock (clock),
      .reset (reset),
      .en    (sck_en),
      .sck   (sck),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   assign req_fire  = req_valid && req_ready;
   assign resp_fire = resp_valid_q && resp_ready;
   // Phases end on the falling edge of their last SCK; that edge also
   // launches the first bit of the next phase.
   assign phase_end = sck_fall && (bit_cnt == 8'd0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      sck_en    = 1'b0;
      cs        = 1'b1;
      dq_out    = 4'h0;
      dq_drive  = 4'h0;
      req_ready = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = out_of_reset;
            if (req_valid && out_of_reset) state_nxt = CMD;
         end
         CMD: begin
            sck_en   = 1'b1;
            cs       = 1'b0;
            dq_out   = {3'b000, tx_sr[31]};
            dq_drive = 4'b0001;
            if (phase_end) state_nxt = ADDR;
         end
         ADDR: begin
            sck_en = 1'b1;
            cs     = 1'b0;
            if (QUAD) begin
               dq_out   = tx_sr[31:28];
               dq_drive = 4'b1111;
            end else begin
               dq_out   = {3'b000, tx_sr[31]};
               dq_drive = 4'b0001;
            end
            if (phase_end) state_nxt = USE_DUMMY ? DUMMY : DATA;
         end
         DUMMY: begin
            sck_en = 1'b1;
            cs     = 1'b0;
            if (phase_end) state_nxt = DATA;
         end
         DATA: begin
            sck_en = 1'b1;
            cs     = 1'b0;
            if (phase_end) state_nxt = RESP;
         end
         RESP: begin
            if (resp_fire) state_nxt = GAP;
         end
         GAP: begin
            if (gap_cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      case (state_nxt)
         ADDR:    phase_last = ADDR_LAST;
         DUMMY:   phase_last = DUMMY_LAST;
         DATA:    phase_last = data_sck_last(QUAD, len_q);
         default: phase_last = 8'd0;
      endcase
   end

   // Receive assembly: nibbles (quad) or dq[1] bits (single), MSB first.
   always_comb begin
      if (QUAD) begin
         rx_byte_nxt = {rx_byte[3:0], dq_in};
         byte_done   = rx_cnt[0];
         byte_idx    = rx_cnt[2:1];
      end else begin
         rx_byte_nxt = {rx_byte[6:0], dq_in[1]};
         byte_done   = &rx_cnt[2:0];
         byte_idx    = rx_cnt[4:3];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_of_reset <= 1'b0;
         tx_sr        <= '0;
         bit_cnt      <= '0;
         len_q        <= '0;
         data_q       <= '0;
         rx_byte      <= '0;
         rx_cnt       <= '0;
         gap_cnt      <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         out_of_reset <= 1'b1;
         if (req_fire) begin
            tx_sr   <= {CMD_BYTE, addr24};
            bit_cnt <= CMD_LAST;
            len_q   <= req_len;
            data_q  <= '0;
            rx_byte <= '0;
            rx_cnt  <= '0;
         end else begin
            if (sck_fall) begin
               if (state == CMD || (state == ADDR && !QUAD))
                  tx_sr <= {tx_sr[30:0], 1'b0};
               else if (state == ADDR)
                  tx_sr <= {tx_sr[27:0], 4'h0};
               bit_cnt <= phase_end ? phase_last : bit_cnt - 8'd1;
            end
            if (sck_rise && state == DATA) begin
               rx_byte <= rx_byte_nxt;
               rx_cnt  <= rx_cnt + 5'd1;
               if (byte_done) data_q[{byte_idx, 3'b000} +: 8] <= rx_byte_nxt;
            end
         end

         // Response is raised one cycle after cs returns high.
         if (state == RESP && !resp_valid_q) resp_valid_q <= 1'b1;
         else if (resp_fire)                 resp_valid_q <= 1'b0;

         if (resp_fire)                         gap_cnt <= GAP_LAST;
         else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = data_q;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// tb_spi_flash_read_ctrl
// Scoreboard bench for spi_flash_read_ctrl with a behavioural flash whose
// byte[i] = i[7:0]. Works in either read mode (SPI_FLASH_QUAD_EN).
module tb_spi_flash_read_ctrl;

`ifdef SPI_FLASH_QUAD_EN
   localparam logic QUAD = 1'b1;
`else
   localparam logic QUAD = 1'b0;
`endif
   localparam int DUMMY  = 8;
   localparam int CS_GAP = 2;
   localparam int N_ADDR = QUAD ? 6 : 24;
   localparam int N_PRE  = QUAD ? (8 + 6 + DUMMY) : 32;
   localparam logic [7:0] EXP_CMD = QUAD ? 8'hEB : 8'h03;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [23:0] req_addr;
   logic [1:0]  req_len;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic        sck, cs, busy;
   logic [3:0]  dq_out, dq_drive;
   logic [3:0]  dq_in = 4'h0;

   always #5 clock = ~clock;

   spi_flash_read_ctrl #(
      .ADDR_BITS    (24),
      .DUMMY_CYCLES (DUMMY),
      .CLK_DIV      (1),
      .CS_GAP       (CS_GAP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_len    (req_len),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .sck        (sck),
      .cs         (cs),
      .dq_out     (dq_out),
      .dq_drive   (dq_drive),
      .dq_in      (dq_in),
      .busy       (busy)
   );

   typedef struct {
      logic [31:0] data;
      int          pulses;
      logic [23:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Flash model: decodes command/address on rising SCK, drives data on falling SCK.
   int          r = 0;
   logic [7:0]  m_cmd;
   logic [23:0] m_addr;
   logic        m_drive_err, m_cs_err;
   logic [3:0]  m_drv;
   int          m_u;
   logic [7:0]  m_b;

   always @(negedge cs or posedge sck) begin
      if (!sck) begin
         r = 0; m_cmd = 8'h0; m_addr = 24'h0; m_drive_err = 1'b0; m_cs_err = 1'b0;
      end else begin
         if (cs !== 1'b0) m_cs_err = 1'b1;
         m_drv = (r < 8) ? 4'b0001 : (r < 8 + N_ADDR) ? (QUAD ? 4'b1111 : 4'b0001) : 4'b0000;
         if (dq_drive !== m_drv) m_drive_err = 1'b1;
         if (r < 8) m_cmd = {m_cmd[6:0], dq_out[0]};
         else if (r < 8 + N_ADDR)
            m_addr = QUAD ? {m_addr[19:0], dq_out} : {m_addr[22:0], dq_out[0]};
         r++;
      end
   end

   always @(negedge sck) begin
      if (r >= N_PRE) begin
         m_u = r - N_PRE;
         if (QUAD) begin
            m_b   = 8'(m_addr + 24'(m_u / 2));
            dq_in = (m_u % 2 == 0) ? m_b[7:4] : m_b[3:0];
         end else begin
            m_b   = 8'(m_addr + 24'(m_u / 8));
            dq_in = {2'b00, m_b[7 - (m_u % 8)], 1'b0};
         end
      end
   end

   // Monitor: every accepted response is checked against the scoreboard.
   exp_t e_mon;
   initial begin
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp: got data %h want no response", resp_data);
            end else begin
               e_mon = exp_q.pop_front();
               chk("resp_data", resp_data, e_mon.data);
               chk("sck_pulses", 32'(r), 32'(e_mon.pulses));
               chk("cmd_byte", {24'h0, m_cmd}, {24'h0, EXP_CMD});
               chk("flash_addr", {8'h0, m_addr}, {8'h0, e_mon.addr});
               chk("dq_drive_phase_err", {31'h0, m_drive_err}, 32'h0);
               chk("cs_low_err", {31'h0, m_cs_err}, 32'h0);
            end
         end
      end
   end

   task automatic issue(input logic [23:0] a, input logic [1:0] l,
                        input logic [31:0] d, input bit expect_resp);
      exp_t e;
      int   n;
      if (expect_resp) begin
         e.data   = d;
         e.pulses = QUAD ? (8 + 6 + DUMMY + 2 * (int'(l) + 1)) : (32 + 8 * (int'(l) + 1));
         e.addr   = a;
         exp_q.push_back(e);
      end
      @(negedge clock);
      req_valid = 1'b1; req_addr = a; req_len = l;
      n = 0;
      while (!req_ready && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_timeout: got req_ready 0 want 1");
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 2000) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got pending %0d want 0", exp_q.size());
      end
   endtask

   int          n;
   logic        stable;
   logic [31:0] hold;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; resp_ready = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_cs", {31'h0, cs}, 32'h1);
      chk("rst_sck", {31'h0, sck}, 32'h0);
      chk("rst_dq", {24'h0, dq_out, dq_drive}, 32'h0);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      reset = 1'b1;
      @(negedge clock);
      chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

      issue(24'h000100, 2'd3, 32'h03020100, 1'b1); wait_idle();
      issue(24'h0000FF, 2'd0, 32'h000000FF, 1'b1); wait_idle();
      issue(24'hFFFFFE, 2'd3, 32'h0100FFFE, 1'b1); wait_idle();
      issue(24'h000010, 2'd3, 32'h13121110, 1'b1); wait_idle();

      // Backpressure and CS gap timing
      resp_ready = 1'b0;
      issue(24'h000020, 2'd2, 32'h00222120, 1'b1);
      n = 0;
      while (!resp_valid && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
      hold = resp_data; stable = 1'b1;
      repeat (20) begin
         @(negedge clock);
         if (!resp_valid || resp_data !== hold || req_ready) stable = 1'b0;
      end
      chk("bp_hold_stable", {31'h0, stable}, 32'h1);
      @(posedge clock);
      #1 resp_ready = 1'b1;
      @(posedge clock);
      n = 0;
      do begin
         @(posedge clock);
         n++;
         #1;
      end while (!req_ready && n < 50);
      chk("gap_to_ready", 32'(n), 32'(CS_GAP));
      wait_idle();

      // Reset in the middle of the address phase
      issue(24'h000080, 2'd3, 32'h0, 1'b0);
      n = 0;
      while (r < 10 && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("reached_addr", {31'h0, (r >= 10)}, 32'h1);
      reset = 1'b0;
      #1;
      chk("abort_cs", {31'h0, cs}, 32'h1);
      chk("abort_sck", {31'h0, sck}, 32'h0);
      chk("abort_dq_drive", {28'h0, dq_drive}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (80) @(negedge clock);
      chk("abort_no_resp_pending", 32'(exp_q.size()), 32'h0);
      issue(24'h000040, 2'd1, 32'h00004140, 1'b1); wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
